// File: rtl/alu_seq16_if.sv
// Request/response handshake and 8-bit ALU command bus for the 16-bit sequencer.
interface alu_seq16_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_flag;
  logic        rsp_err;
  logic [3:0]  alu_cmd;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_f_in;
  logic [7:0]  alu_rslt;
  logic        alu_out;

  // Sequencer side
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_rslt, alu_out,
    output req_ready, rsp_valid, rsp_result, rsp_flag, rsp_err,
           alu_cmd, alu_a, alu_b, alu_f_in
  );

  // Controller + ALU side
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_rslt, alu_out,
    input  req_ready, rsp_valid, rsp_result, rsp_flag, rsp_err,
           alu_cmd, alu_a, alu_b, alu_f_in
  );
endinterface

// File: rtl/alu_seq16.sv
// 16-bit operations built from byte-wise commands on an 8-bit combinational ALU.
// One request at a time; the carry/shift flag is chained between byte steps.
module alu_seq16 (
  input  logic        clk,
  input  logic        rst_n,
  alu_seq16_if.slave  bus
);
  localparam logic [3:0] CMD_ADD  = 4'b0000;
  localparam logic [3:0] CMD_SUB  = 4'b0001;
  localparam logic [3:0] CMD_CMP  = 4'b0011;
  localparam logic [3:0] CMD_SHC  = 4'b0110;
  localparam logic [3:0] CMD_ADDC = 4'b0111;
  localparam logic [3:0] CMD_ADDI = 4'b1000;
  localparam logic [3:0] CMD_NOP  = 4'b1111;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_CMP = 3'b100;

  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_FIX, S_SA, S_SB, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] res_q, res_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        carry_q, carry_d;
  logic        flag_q, flag_d;
  logic        err_q, err_d;

  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      a_q     <= 16'd0;
      b_q     <= 16'd0;
      res_q   <= 16'd0;
      cnt_q   <= 4'd0;
      carry_q <= 1'b0;
      flag_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      flag_q  <= flag_d;
      err_q   <= err_d;
    end
  end

  // Next state, ALU command for the current step, and capture of the ALU result
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    cnt_d        = cnt_q;
    carry_d      = carry_q;
    flag_d       = flag_q;
    err_d        = err_q;
    bus.alu_cmd  = CMD_NOP;
    bus.alu_a    = 8'h00;
    bus.alu_b    = 8'h00;
    bus.alu_f_in = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          res_d   = 16'h0000;
          cnt_d   = bus.req_b[3:0];
          carry_d = 1'b0;
          flag_d  = 1'b0;
          err_d   = 1'b0;
          case (bus.req_op)
            OP_ADD, OP_SUB, OP_CMP: state_d = S_LO;
            OP_SHL, OP_SHR: begin
              // Shifts work in place on the result register
              res_d   = bus.req_a;
              state_d = (bus.req_b[3:0] == 4'd0) ? S_DONE : S_SA;
            end
            default: begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end
      end

      S_LO: begin
        bus.alu_a = a_q[7:0];
        bus.alu_b = b_q[7:0];
        if (op_q == OP_SUB)      bus.alu_cmd = CMD_SUB;
        else if (op_q == OP_CMP) bus.alu_cmd = CMD_CMP;
        else                     bus.alu_cmd = CMD_ADD;
        // Compare leaves the result at zero
        if (op_q != OP_CMP) res_d[7:0] = bus.alu_rslt;
        carry_d = bus.alu_out;
        state_d = S_HI;
      end

      S_HI: begin
        bus.alu_a = a_q[15:8];
        bus.alu_b = b_q[15:8];
        state_d   = S_DONE;
        if (op_q == OP_ADD) begin
          bus.alu_cmd  = CMD_ADDC;
          bus.alu_f_in = carry_q;
          res_d[15:8]  = bus.alu_rslt;
          flag_d       = bus.alu_out;
        end else if (op_q == OP_SUB) begin
          bus.alu_cmd = CMD_SUB;
          res_d[15:8] = bus.alu_rslt;
          // A low borrow only propagates out of the word when the high difference is zero
          flag_d      = bus.alu_out | (carry_q & (bus.alu_rslt == 8'h00));
          if (carry_q) state_d = S_FIX;
        end else begin
          bus.alu_cmd = CMD_CMP;
          flag_d      = carry_q & bus.alu_out;
        end
      end

      S_FIX: begin
        // Apply the low-byte borrow to the high byte: hi + (-1)
        bus.alu_cmd = CMD_ADDI;
        bus.alu_a   = res_q[15:8];
        bus.alu_b   = 8'hFF;
        res_d[15:8] = bus.alu_rslt;
        state_d     = S_DONE;
      end

      S_SA: begin
        // First byte of a 1-bit shift: the byte whose outgoing bit feeds the other byte
        bus.alu_cmd = CMD_SHC;
        if (op_q == OP_SHL) begin
          bus.alu_a  = res_q[7:0];
          bus.alu_b  = 8'h02;
          res_d[7:0] = bus.alu_rslt;
        end else begin
          bus.alu_a   = res_q[15:8];
          bus.alu_b   = 8'h0E;
          res_d[15:8] = bus.alu_rslt;
        end
        carry_d = bus.alu_out;
        state_d = S_SB;
      end

      S_SB: begin
        bus.alu_cmd  = CMD_SHC;
        bus.alu_f_in = carry_q;
        if (op_q == OP_SHL) begin
          bus.alu_a   = res_q[15:8];
          bus.alu_b   = 8'h02;
          res_d[15:8] = bus.alu_rslt;
        end else begin
          bus.alu_a  = res_q[7:0];
          bus.alu_b  = 8'h0E;
          res_d[7:0] = bus.alu_rslt;
        end
        flag_d  = bus.alu_out;
        cnt_d   = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? S_DONE : S_SA;
      end

      S_DONE: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs are pure decodes of the state and result registers
  always_comb begin
    bus.req_ready  = (state_q == S_IDLE);
    bus.rsp_valid  = (state_q == S_DONE);
    bus.rsp_result = res_q;
    bus.rsp_flag   = flag_q;
    bus.rsp_err    = err_q;
  end
endmodule

// File: tb/tb_alu_seq16.sv
// Bench for alu_seq16: behavioural 8-bit ALU plus a scoreboard of expected responses.
module tb_alu_seq16;
  logic clk;
  logic rst_n;
  alu_seq16_if bus ();

  alu_seq16 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        flag;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   total;
  int   bad;

  logic [8:0] alu_s;

  // Combinational 8-bit ALU seen by the sequencer
  always_comb begin
    alu_s        = 9'd0;
    bus.alu_rslt = 8'h00;
    bus.alu_out  = 1'b0;
    case (bus.alu_cmd)
      4'h0: begin
        alu_s        = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_rslt = alu_s[7:0];
        bus.alu_out  = alu_s[8];
      end
      4'h1: begin
        bus.alu_rslt = bus.alu_a - bus.alu_b;
        bus.alu_out  = (bus.alu_a < bus.alu_b);
      end
      4'h3: bus.alu_out = (bus.alu_a == bus.alu_b);
      4'h6: begin
        if (bus.alu_b[3]) begin
          bus.alu_rslt = {bus.alu_f_in, bus.alu_a[7:1]};
          bus.alu_out  = bus.alu_a[0];
        end else begin
          bus.alu_rslt = {bus.alu_a[6:0], bus.alu_f_in};
          bus.alu_out  = bus.alu_a[7];
        end
      end
      4'h7: begin
        alu_s        = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'd0, bus.alu_f_in};
        bus.alu_rslt = alu_s[7:0];
        bus.alu_out  = alu_s[8];
      end
      4'h8: bus.alu_rslt = bus.alu_a + bus.alu_b;
      default: ;
    endcase
  end

  function automatic exp_t mk(input logic [15:0] res, input logic flag, input logic err, input int lat);
    exp_t e;
    e.res = res; e.flag = flag; e.err = err; e.lat = lat;
    return e;
  endfunction

  // Word-level reference used for randomised requests
  function automatic exp_t ref_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic [16:0] s;
    int n;
    e = mk(16'h0000, 1'b0, 1'b0, 0);
    n = int'(b[3:0]);
    case (op)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b};
        e.res = s[15:0]; e.flag = s[16]; e.lat = 2;
      end
      3'b001: begin
        e.res = a - b; e.flag = (a < b); e.lat = (a[7:0] < b[7:0]) ? 3 : 2;
      end
      3'b010: begin
        e.res = a << n; e.flag = (n == 0) ? 1'b0 : a[16 - n]; e.lat = 2 * n;
      end
      3'b011: begin
        e.res = a >> n; e.flag = (n == 0) ? 1'b0 : a[n - 1]; e.lat = 2 * n;
      end
      3'b100: begin
        e.flag = (a == b); e.lat = 2;
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  task automatic start_req(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input exp_t e);
    int g;
    g = 0;
    while (!bus.req_ready && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (!bus.req_ready) begin
      total++; bad++;
      $display("FAIL req_ready_timeout: req_ready=%b required 1", bus.req_ready);
    end
    sb_q.push_back(e);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input bit chk_fix);
    int   lat;
    bit   saw_fix;
    exp_t e;
    lat = 0;
    saw_fix = 1'b0;
    while (!bus.rsp_valid && lat < 200) begin
      if (bus.alu_cmd == 4'b1000) saw_fix = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.rsp_valid) begin
      total++; bad++;
      $display("FAIL %s_timeout: rsp_valid=%b required 1", name, bus.rsp_valid);
    end
    if (sb_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s_scoreboard: got response with %0d expected entries", name, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      total++;
      if (bus.rsp_result !== e.res) begin
        bad++; $display("FAIL %s_result: got %h required %h", name, bus.rsp_result, e.res);
      end
      total++;
      if (bus.rsp_flag !== e.flag) begin
        bad++; $display("FAIL %s_flag: got %b required %b", name, bus.rsp_flag, e.flag);
      end
      total++;
      if (bus.rsp_err !== e.err) begin
        bad++; $display("FAIL %s_err: got %b required %b", name, bus.rsp_err, e.err);
      end
      total++;
      if (lat != e.lat) begin
        bad++; $display("FAIL %s_latency: got %0d required %0d", name, lat, e.lat);
      end
    end
    if (chk_fix) begin
      total++;
      if (saw_fix !== 1'b1) begin
        bad++; $display("FAIL %s_fix_step: saw ADDI=%b required 1", name, saw_fix);
      end
    end
  endtask

  task automatic release_rsp(input string name);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_release: rsp_valid=%b req_ready=%b required 0/1", name, bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic do_req(input string name, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input exp_t e, input bit chk_fix);
    start_req(op, a, b, e);
    wait_rsp(name, chk_fix);
    release_rsp(name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_handshake: req_ready=%b rsp_valid=%b required 1/0", bus.req_ready, bus.rsp_valid);
    end
    total++;
    if (bus.rsp_flag !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_result !== 16'h0000) begin
      bad++; $display("FAIL reset_rsp: flag=%b err=%b result=%h required 0/0/0000", bus.rsp_flag, bus.rsp_err, bus.rsp_result);
    end
    total++;
    if (bus.alu_cmd !== 4'hF || bus.alu_a !== 8'h00 || bus.alu_b !== 8'h00 || bus.alu_f_in !== 1'b0) begin
      bad++; $display("FAIL reset_alu: cmd=%h a=%h b=%h f=%b required F/00/00/0", bus.alu_cmd, bus.alu_a, bus.alu_b, bus.alu_f_in);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    do_req("add_carry_chain", 3'b000, 16'h12FF, 16'h0001, mk(16'h1300, 1'b0, 1'b0, 2), 1'b0);
    do_req("add_wrap",        3'b000, 16'hFFFF, 16'h0001, mk(16'h0000, 1'b1, 1'b0, 2), 1'b0);
  endtask

  task automatic test_sub();
    do_req("sub_fix",    3'b001, 16'h1200, 16'h0001, mk(16'h11FF, 1'b0, 1'b0, 3), 1'b1);
    do_req("sub_under",  3'b001, 16'h0000, 16'h0001, mk(16'hFFFF, 1'b1, 1'b0, 3), 1'b1);
    do_req("sub_plain",  3'b001, 16'h0305, 16'h0102, mk(16'h0203, 1'b0, 1'b0, 2), 1'b0);
  endtask

  task automatic test_shift();
    do_req("shl_1",  3'b010, 16'h8001, 16'h0001, mk(16'h0002, 1'b1, 1'b0, 2), 1'b0);
    do_req("shr_4",  3'b011, 16'h0003, 16'h0004, mk(16'h0000, 1'b0, 1'b0, 8), 1'b0);
    do_req("shl_0",  3'b010, 16'hABCD, 16'hFFF0, mk(16'hABCD, 1'b0, 1'b0, 0), 1'b0);
    do_req("shr_9",  3'b011, 16'h8100, 16'h0009, mk(16'h0040, 1'b1, 1'b0, 18), 1'b0);
  endtask

  task automatic test_cmp_illegal();
    do_req("cmp_eq",  3'b100, 16'h5A5A, 16'h5A5A, mk(16'h0000, 1'b1, 1'b0, 2), 1'b0);
    do_req("cmp_ne",  3'b100, 16'h5A5A, 16'h5A5B, mk(16'h0000, 1'b0, 1'b0, 2), 1'b0);
    do_req("illegal", 3'b111, 16'h1234, 16'h5678, mk(16'h0000, 1'b0, 1'b1, 0), 1'b0);
  endtask

  task automatic test_backpressure();
    start_req(3'b000, 16'h0102, 16'h0304, mk(16'h0406, 1'b0, 1'b0, 2));
    wait_rsp("bp_add", 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.req_valid = 1'b1;
        bus.req_op    = 3'b000;
        bus.req_a     = 16'h1111;
        bus.req_b     = 16'h2222;
      end else begin
        bus.req_valid = 1'b0;
      end
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 16'h0406 || bus.rsp_flag !== 1'b0 ||
          bus.req_ready !== 1'b0 || bus.alu_cmd !== 4'hF) begin
        bad++;
        $display("FAIL bp_hold_%0d: valid=%b result=%h flag=%b ready=%b cmd=%h required 1/0406/0/0/F",
                 i, bus.rsp_valid, bus.rsp_result, bus.rsp_flag, bus.req_ready, bus.alu_cmd);
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    release_rsp("bp");
    @(posedge clk); #1;
    total++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.alu_cmd !== 4'hF) begin
      bad++;
      $display("FAIL bp_no_accept: ready=%b valid=%b cmd=%h required 1/0/F", bus.req_ready, bus.rsp_valid, bus.alu_cmd);
    end
  endtask

  task automatic test_reset_mid();
    exp_t dropped;
    start_req(3'b010, 16'h1234, 16'h0008, mk(16'h3400, 1'b0, 1'b0, 16));
    total++;
    if (bus.alu_cmd !== 4'b0110) begin
      bad++; $display("FAIL rst_mid_in_sa: cmd=%h required 6", bus.alu_cmd);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dropped = sb_q.pop_front();
    total++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.alu_cmd !== 4'hF) begin
      bad++;
      $display("FAIL rst_mid_idle: ready=%b valid=%b cmd=%h required 1/0/F (dropped res %h)",
               bus.req_ready, bus.rsp_valid, bus.alu_cmd, dropped.res);
    end
    do_req("rst_mid_add", 3'b000, 16'hFFFF, 16'h0001, mk(16'h0000, 1'b1, 1'b0, 2), 1'b0);
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if (i % 4 == 0) b[7:0] = a[7:0] + 8'd1;
      do_req("rand", op, a, b, ref_model(op, a, b), 1'b0);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'b000;
    bus.req_a     = 16'h0000;
    bus.req_b     = 16'h0000;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_cmp_illegal();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
